vec_load_store_unit: RTL
========================

Name: vec_load_store_unit

Overview:
- Sequencer between the vector register file and the 512-word x 32-bit wide data memory.
- Accepts LOAD/STORE commands over a valid/ready handshake and drives the memory's address, write-enable and 512-bit write bus.
- Captures the memory's 512-bit read bus into one of NREG vector registers.
- Also provides one combinational read port and one write port to the vector registers for the ALU stage.

Parameters:
- NREG, 4, number of 512-bit vector registers.
- ADDR_W, 9, memory word-address width (512 words).
- LANES, 16, 32-bit words per vector line.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  unit can accept a command.
- cmd_op  input  1  0 = LOAD (memory->register), 1 = STORE (register->memory).
- cmd_reg  input  $clog2(NREG)  target/source vector register.
- cmd_addr  input  ADDR_W  base word address.
- mem_addr  output  ADDR_W  address to memory.
- mem_en  output  1  memory write enable.
- mem_wdata  output  512  line to memory.
- mem_rdata  input  512  line from memory, combinational on mem_addr.
- rd_sel  input  $clog2(NREG)  ALU read select.
- rd_data  output  512  combinational contents of register rd_sel.
- alu_we  input  1  ALU register write.
- alu_sel  input  $clog2(NREG)  ALU write target.
- alu_wdata  input  512  ALU write data.
- busy  output  1  FSM not IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle rejection pulse; only with the optional feature.

Behaviour:
- Reset, while reset=0, asynchronous:
  - state=IDLE, all vector registers=0.
  - mem_addr=0, mem_en=0, mem_wdata=0.
  - done=0, err=0, busy=0.
  - cmd_ready=0 while reset is low; 1 from the first cycle after release.
- Lane mapping: lane i = bits [32i+31:32i] ↔ memory word (cmd_addr+i) mod 512. The unit passes the address unchanged; the memory performs wrap-around.
- cmd_ready = (state==IDLE). A command is accepted on a rising edge with cmd_valid & cmd_ready. cmd_op, cmd_reg and cmd_addr are latched at that edge.
- States: IDLE → ISSUE → (LOAD: WAIT → CAPTURE | STORE: WRITE) → DONE → IDLE.
- ISSUE: mem_addr=latched address. For STORE, mem_wdata=latched copy of the source register taken at ISSUE entry. mem_en=0.
- WAIT (LOAD only): one settle cycle for the memory read path.
- CAPTURE: at the closing rising edge, vreg[reg] <= mem_rdata.
- WRITE (STORE only): mem_en=1 for exactly this one cycle. mem_addr and mem_wdata are held stable. The memory commits on that cycle's falling edge.
- DONE: done=1 for one cycle, then IDLE.
- Latency from the accept edge:
  - LOAD: done high in the 4th cycle; register updated at the edge entering DONE.
  - STORE: done high in the 3rd cycle.
- Back-to-back: a command may be accepted in the cycle after DONE (IDLE). Maximum throughput is one command per 4 (STORE) or 5 (LOAD) cycles.
- mem_addr and mem_wdata hold their last values in IDLE/DONE. mem_en is 0 in every state except WRITE.
- ALU port:
  - alu_we writes alu_wdata to vreg[alu_sel] at the rising edge, in any state.
  - If alu_we targets the same register at the same edge as a LOAD capture, the LOAD data wins.
  - An ALU write to a STORE's source register after ISSUE does not change the stored data.
- rd_data reflects register contents combinationally, including the value just written at the previous edge.
- Reset mid-operation: the FSM aborts to IDLE and mem_en drops immediately. A STORE aborted before its WRITE falling edge leaves memory unchanged. No done pulse is produced.

Optional Feature:
- Macro VLSU_BOUNDS_CHECK_EN.
- Defined: a command with cmd_addr > 512-LANES (i.e. > 496) is still accepted, but goes IDLE → DONE with err=1 and done=1 in the same cycle. There is no memory access and no register change.
- Undefined: err is tied 0 and every address proceeds normally; wrapping lines are handled by the memory.

Test Plan:
- Reset then LOAD reg1 from addr 0x000, where memory words 0..15 = 0x00000000..0x0000000F → done in cycle 4; rd_sel=1 gives lane i = i; mem_en never high.
- ALU write reg2 = lanes all 0xDEADBEEF; STORE reg2 to addr 0x020 → mem_en high exactly 1 cycle, mem_addr=0x020; then LOAD reg3 from 0x020 → reg3 lanes all 0xDEADBEEF.
- STORE then LOAD at addr 0x1F8 (feature off) → memory words 0x1F8..0x1FF and 0x000..0x007 written; the reload returns an identical line. Feature on → err=1, done=1, memory unchanged.
- LOAD reg0 with alu_we to reg0 asserted at the capture edge → reg0 holds the memory data, not the ALU data; cmd_valid held high during busy → the second command is accepted only when cmd_ready=1.
- Assert reset=0 during WRITE before the falling edge → mem_en=0 immediately, memory word unchanged, all registers 0, no done pulse; after release cmd_ready=1 on the next cycle.

Source files
------------

// File: rtl/vec_load_store_unit.sv
// Vector load/store sequencer between a NREG x 512-bit register file and a 512-word line memory.
// Define VLSU_BOUNDS_CHECK_EN to reject commands whose line would run past the last memory word.
module vec_load_store_unit #(
    parameter int unsigned NREG   = 4,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned LANES  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_op_i,
    input  logic [$clog2(NREG)-1:0] cmd_reg_i,
    input  logic [ADDR_W-1:0]       cmd_addr_i,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic                    mem_en_o,
    output logic [LANES*32-1:0]     mem_wdata_o,
    input  logic [LANES*32-1:0]     mem_rdata_i,
    input  logic [$clog2(NREG)-1:0] rd_sel_i,
    output logic [LANES*32-1:0]     rd_data_o,
    input  logic                    alu_we_i,
    input  logic [$clog2(NREG)-1:0] alu_sel_i,
    input  logic [LANES*32-1:0]     alu_wdata_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int unsigned DataW = LANES * 32;
    localparam int unsigned RegW  = $clog2(NREG);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCapture,
        StWrite,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic                op_q;
    logic [RegW-1:0]     reg_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DataW-1:0]    wdata_q;
    logic                err_q, err_d;
    logic [DataW-1:0]    vreg_q [NREG];
    logic                accept;
    logic                oob;

`ifdef VLSU_BOUNDS_CHECK_EN
    localparam int unsigned MaxBase = (1 << ADDR_W) - LANES;
    assign oob = 32'(cmd_addr_i) > MaxBase;
`else
    assign oob = 1'b0;
`endif

    // Ready is masked by reset so nothing is offered while reset is held.
    assign cmd_ready_o = rst_ni & (state_q == StIdle);
    assign accept      = cmd_valid_i & cmd_ready_o;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    err_d   = oob;
                    state_d = oob ? StDone : StIssue;
                end
            end
            StIssue:   state_d = op_q ? StWrite : StWait;
            StWait:    state_d = StCapture;
            StCapture: state_d = StDone;
            StWrite:   state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Command fields; the store line is snapshotted at accept so later ALU writes cannot leak in.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q    <= 1'b0;
            reg_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q  <= cmd_op_i;
            reg_q <= cmd_reg_i;
            if (!oob) begin
                addr_q <= cmd_addr_i;
                if (cmd_op_i) begin
                    wdata_q <= vreg_q[cmd_reg_i];
                end
            end
        end
    end

    // Capture is written after the ALU write so a colliding LOAD wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                vreg_q[i] <= '0;
            end
        end else begin
            if (alu_we_i) begin
                vreg_q[alu_sel_i] <= alu_wdata_i;
            end
            if (state_q == StCapture) begin
                vreg_q[reg_q] <= mem_rdata_i;
            end
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_en_o    = (state_q == StWrite);
    assign rd_data_o   = vreg_q[rd_sel_i];
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign err_o       = (state_q == StDone) & err_q;

endmodule
